// File: rtl/mux4_scan_ctrl_pkg.sv
// Shared definitions for the 4-channel mux scan controller: state encoding,
// channel constants and the next-enabled-channel search.
package mux4_scan_ctrl_pkg;

  localparam int unsigned CH_W   = 2;
  localparam int          NUM_CH = 4;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StScan = 2'd1,
    StDone = 2'd2
  } state_e;

  localparam logic [CH_W-1:0] CH_A = 2'd0;
  localparam logic [CH_W-1:0] CH_B = 2'd1;
  localparam logic [CH_W-1:0] CH_C = 2'd2;
  localparam logic [CH_W-1:0] CH_D = 2'd3;

  typedef struct packed {
    logic            found;
    logic [CH_W-1:0] ch;
  } next_ch_t;

  // Lowest set bit of mask strictly above cur; found=0 when none exists.
  function automatic next_ch_t next_set_bit(input logic [NUM_CH-1:0] mask,
                                            input logic [CH_W-1:0]   cur);
    next_ch_t r;
    r.found = 1'b0;
    r.ch    = cur;
    // Descending walk so the lowest qualifying bit is the one left in r.
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (i > int'(cur) && mask[i]) begin
        r.found = 1'b1;
        r.ch    = CH_W'(i);
      end
    end
    return r;
  endfunction

  // Lowest set bit of mask; CH_A when mask is empty (caller guards that case).
  function automatic logic [CH_W-1:0] lowest_set_bit(input logic [NUM_CH-1:0] mask);
    next_ch_t r;
    if (mask[0]) begin
      return CH_A;
    end
    r = next_set_bit(mask, CH_A);
    return r.ch;
  endfunction

endpackage

// File: rtl/mux4_scan_ctrl_if.sv
// Bus between the scan controller and its surroundings: scan control in,
// mux select out, sampled mux output back in, frame readout out.
interface mux4_scan_ctrl_if;
  logic       en;
  logic [3:0] mask;
  logic       y;
  logic       sel1;
  logic       sel2;
  logic [3:0] frame;
  logic       frame_valid;
  logic       busy;

  modport master (
    output en, mask, y,
    input  sel1, sel2, frame, frame_valid, busy
  );

  modport slave (
    input  en, mask, y,
    output sel1, sel2, frame, frame_valid, busy
  );
endinterface

// File: rtl/mux4.sv
// Plain 4-to-1 multiplexer: {sel1, sel2} picks a, b, c or d.
module mux4 (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  input  logic d_i,
  input  logic sel1_i,
  input  logic sel2_i,
  output logic y_o
);

  // Select decode.
  always_comb begin
    y_o = a_i;
    unique case ({sel1_i, sel2_i})
      2'b00:   y_o = a_i;
      2'b01:   y_o = b_i;
      2'b10:   y_o = c_i;
      2'b11:   y_o = d_i;
      default: y_o = a_i;
    endcase
  end

endmodule

// File: rtl/mux4_dwell_counter.sv
// Down-counter timing how long a channel stays selected; zero_o marks the
// edge on which the channel's dwell ends.
module mux4_dwell_counter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Load has priority over decrement.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/mux4_scan_ctrl.sv
// Scan controller: walks the mux select through enabled channels in
// ascending order, samples y at the end of each dwell and publishes the
// collected 4-bit frame with a one-cycle valid pulse.
module mux4_scan_ctrl
  import mux4_scan_ctrl_pkg::*;
#(
  parameter int unsigned DWELL = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic clk,
  input  logic rst,
  mux4_scan_ctrl_if.slave bus
);

  localparam logic [CNT_W-1:0] DwellLoad = CNT_W'(DWELL - 1);

  state_e          state_q, state_d;
  logic [CH_W-1:0] ch_q, ch_d;
  logic [3:0]      mask_q, mask_d;
  logic [3:0]      shadow_q, shadow_d;
  logic [3:0]      frame_q, frame_d;
  logic            valid_q, valid_d;

  logic            cnt_load;
  logic            cnt_dec;
  logic            cnt_zero;
  logic [3:0]      sampled;
  next_ch_t        nxt;
  logic [CH_W-1:0] first_ch;

  assign nxt      = next_set_bit(mask_q, ch_q);
  assign first_ch = lowest_set_bit(bus.mask);

  mux4_dwell_counter #(
    .CNT_W (CNT_W)
  ) u_dwell (
    .clk        (clk),
    .rst        (rst),
    .load_i     (cnt_load),
    .load_val_i (DwellLoad),
    .dec_i      (cnt_dec),
    .zero_o     (cnt_zero)
  );

  // Next-state: frame start, per-channel dwell and frame completion.
  always_comb begin
    state_d  = state_q;
    ch_d     = ch_q;
    mask_d   = mask_q;
    shadow_d = shadow_q;
    frame_d  = frame_q;
    valid_d  = 1'b0;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;

    // Shadow as it would be with the current channel's sample folded in.
    sampled       = shadow_q;
    sampled[ch_q] = bus.y;

    unique case (state_q)
      StIdle, StDone: begin
        if (bus.en && (bus.mask != '0)) begin
          mask_d   = bus.mask;
          ch_d     = first_ch;
          cnt_load = 1'b1;
          state_d  = StScan;
        end else begin
          ch_d    = CH_A;
          state_d = StIdle;
        end
      end
      StScan: begin
        if (!cnt_zero) begin
          cnt_dec = 1'b1;
        end else begin
          shadow_d = sampled;
          if (nxt.found) begin
            ch_d     = nxt.ch;
            cnt_load = 1'b1;
          end else begin
            // Skipped channels may hold stale shadow bits; mask them out.
            frame_d = sampled & mask_q;
            valid_d = 1'b1;
            state_d = StDone;
          end
        end
      end
      default: begin
        ch_d    = CH_A;
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      ch_q     <= CH_A;
      mask_q   <= '0;
      shadow_q <= '0;
      frame_q  <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      ch_q     <= ch_d;
      mask_q   <= mask_d;
      shadow_q <= shadow_d;
      frame_q  <= frame_d;
      valid_q  <= valid_d;
    end
  end

  assign bus.sel1        = ch_q[1];
  assign bus.sel2        = ch_q[0];
  assign bus.frame       = frame_q;
  assign bus.frame_valid = valid_q;
  assign bus.busy        = (state_q != StIdle);

endmodule

// File: tb/tb_mux4_scan_ctrl.sv
// Bench for mux4_scan_ctrl: the real mux closes the y loop, a schedule-queue
// model predicts every output each cycle, and directed scenarios pin
// latencies and frame values by hand.
module tb_mux4_scan_ctrl;
  import mux4_scan_ctrl_pkg::*;

  localparam int Dwell = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic a = 1'b0, b = 1'b0, c = 1'b0, d = 1'b0;
  logic a2 = 1'b0;
  logic zero = 1'b0;
  logic [3:0] din;
  assign din = {d, c, b, a};

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mux4_scan_ctrl_if bus ();
  mux4_scan_ctrl_if bus2 ();

  mux4 u_mux (
    .a_i    (a),
    .b_i    (b),
    .c_i    (c),
    .d_i    (d),
    .sel1_i (bus.sel1),
    .sel2_i (bus.sel2),
    .y_o    (bus.y)
  );

  mux4_scan_ctrl #(
    .DWELL (Dwell),
    .CNT_W (8)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  mux4 u_mux2 (
    .a_i    (a2),
    .b_i    (zero),
    .c_i    (zero),
    .d_i    (zero),
    .sel1_i (bus2.sel1),
    .sel2_i (bus2.sel2),
    .y_o    (bus2.y)
  );

  mux4_scan_ctrl #(
    .DWELL (2),
    .CNT_W (8)
  ) u_dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- model: one queue slot per selected cycle ----------------
  typedef struct {
    int ch;
    bit last;
  } slot_t;

  slot_t      sched[$];
  logic [3:0] m_frame = '0;
  logic [3:0] m_pend  = '0;
  logic [3:0] m_mask  = '0;
  bit         m_valid = 1'b0;
  int         m_sel   = 0;

  always @(posedge clk or posedge rst) begin
    slot_t s;
    if (rst) begin
      sched.delete();
      m_frame = '0;
      m_pend  = '0;
      m_mask  = '0;
      m_valid = 1'b0;
      m_sel   = 0;
    end else if (sched.size() > 0) begin
      s = sched.pop_front();
      if (s.last) m_pend[s.ch] = din[s.ch];
      if (sched.size() == 0) begin
        m_frame = m_pend & m_mask;
        m_valid = 1'b1;
        m_sel   = s.ch;
      end else begin
        m_sel = sched[0].ch;
      end
    end else begin
      m_valid = 1'b0;
      if (bus.en && bus.mask != 4'b0000) begin
        m_mask = bus.mask;
        m_pend = '0;
        for (int ch = 0; ch < 4; ch++) begin
          if (m_mask[ch]) begin
            for (int k = 0; k < Dwell; k++) begin
              s.ch   = ch;
              s.last = (k == Dwell - 1);
              sched.push_back(s);
            end
          end
        end
        m_sel = sched[0].ch;
      end else begin
        m_sel = 0;
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    check("sel", int'({bus.sel1, bus.sel2}), m_sel);
    check("busy", int'(bus.busy), int'(sched.size() > 0 || m_valid));
    check("frame", int'(bus.frame), int'(m_frame));
    check("frame_valid", int'(bus.frame_valid), int'(m_valid));
  end

  // ---------------- DWELL=2 instance: a toggles every cycle ----------------
  always @(negedge clk) a2 = ~a2;

  int   cyc2 = 0;
  int   last2 = -1;
  int   n_pulse2 = 0;
  logic a2_at_edge = 1'b0;

  always @(posedge clk) begin
    cyc2++;
    a2_at_edge = a2;
  end

  always @(negedge clk) begin
    if (bus2.frame_valid) begin
      check("t6_sample", int'(bus2.frame[0]), int'(a2_at_edge));
      check("t6_upper", int'(bus2.frame[3:1]), 0);
      if (last2 >= 0) check("t6_period", cyc2 - last2, 3);
      last2 = cyc2;
      n_pulse2++;
    end
  end

  // ---------------- stimulus helpers ----------------
  // Present en/mask for one edge (edge 0), then apply m_after; return the
  // number of edges from edge 0 to the frame_valid pulse (-1 on timeout).
  task automatic scan(input logic [3:0] m, input logic [3:0] m_after, input bit hold,
                      output int edges);
    @(posedge clk);
    #1;
    bus.mask = m;
    bus.en   = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) bus.en = 1'b0;
    bus.mask = m_after;
    edges = -1;
    for (int n = 1; n <= 300; n++) begin
      @(posedge clk);
      #1;
      if (bus.frame_valid) begin
        edges = n;
        break;
      end
    end
  endtask

  task automatic wait_valid(output int edges);
    edges = -1;
    for (int n = 1; n <= 300; n++) begin
      @(posedge clk);
      #1;
      if (bus.frame_valid) begin
        edges = n;
        break;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int e;
    int nbusy;
    int nval;

    bus.en    = 1'b0;
    bus.mask  = 4'b0000;
    bus2.en   = 1'b0;
    bus2.mask = 4'b0000;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_sel", int'({bus.sel1, bus.sel2}), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_frame", int'(bus.frame), 0);
    check("rst_valid", int'(bus.frame_valid), 0);
    repeat (4) @(posedge clk);

    // Full scan, single en pulse.
    a = 1'b1; b = 1'b0; c = 1'b1; d = 1'b0;
    scan(4'b1111, 4'b1111, 1'b0, e);
    check("t2_latency", e, 16);
    check("t2_frame", int'(bus.frame), 4'b0101);
    @(posedge clk);
    #1;
    check("t2_valid_drop", int'(bus.frame_valid), 0);
    check("t2_idle_busy", int'(bus.busy), 0);
    check("t2_idle_sel", int'({bus.sel1, bus.sel2}), int'(CH_A));
    check("t2_frame_hold", int'(bus.frame), 4'b0101);

    // Sparse mask: a and c masked out.
    a = 1'b1; b = 1'b1; c = 1'b1; d = 1'b1;
    scan(4'b1010, 4'b1010, 1'b0, e);
    check("t3_latency", e, 8);
    check("t3_frame", int'(bus.frame), 4'b1010);

    // Empty mask with en held: never leaves idle.
    @(posedge clk);
    #1;
    bus.mask = 4'b0000;
    bus.en   = 1'b1;
    nbusy = 0;
    nval  = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      #1;
      if (bus.busy) nbusy++;
      if (bus.frame_valid) nval++;
    end
    bus.en = 1'b0;
    check("t4_empty_busy", nbusy, 0);
    check("t4_empty_valid", nval, 0);

    // Mask change mid-scan is ignored until the next frame.
    a = 1'b0; b = 1'b1; c = 1'b1; d = 1'b0;
    scan(4'b1111, 4'b0001, 1'b0, e);
    check("t4_midmask_latency", e, 16);
    check("t4_midmask_frame", int'(bus.frame), 4'b0110);
    a = 1'b1;
    scan(4'b0001, 4'b0001, 1'b0, e);
    check("t4_next_latency", e, 4);
    check("t4_next_frame", int'(bus.frame), 4'b0001);

    // Continuous scanning; d toggled between frames.
    a = 1'b1; b = 1'b1; c = 1'b0; d = 1'b0;
    scan(4'b1111, 4'b1111, 1'b1, e);
    check("t5_first_latency", e, 16);
    check("t5_frame0", int'(bus.frame), 4'b0011);
    d = 1'b1;
    wait_valid(e);
    check("t5_period1", e, 17);
    check("t5_frame1", int'(bus.frame), 4'b1011);
    d = 1'b0;
    wait_valid(e);
    check("t5_period2", e, 17);
    check("t5_frame2", int'(bus.frame), 4'b0011);

    // Async reset in the middle of channel b's dwell.
    repeat (6) @(posedge clk);
    #1;
    check("pre_rst_sel", int'({bus.sel1, bus.sel2}), int'(CH_B));
    #2 rst = 1'b1;
    #1;
    check("midrst_sel", int'({bus.sel1, bus.sel2}), 0);
    check("midrst_busy", int'(bus.busy), 0);
    check("midrst_frame", int'(bus.frame), 0);
    check("midrst_valid", int'(bus.frame_valid), 0);
    bus.en = 1'b0;
    @(posedge clk);
    #3 rst = 1'b0;
    nval = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (bus.frame_valid) nval++;
    end
    check("post_rst_valid", nval, 0);

    // DWELL=2 instance, single channel, continuous.
    @(posedge clk);
    #1;
    bus2.mask = 4'b0001;
    bus2.en   = 1'b1;
    repeat (30) @(posedge clk);
    @(negedge clk);
    #1;
    check("t6_pulse_count", n_pulse2, 10);
    bus2.en = 1'b0;
    repeat (4) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mux4_scan_ctrl.md
Name: mux4_scan_ctrl

Overview:
Upstream sequencer and downstream sampler for the 4-to-1 multiplexer stage. Drives the mux select lines sel1/sel2 through the enabled input channels in ascending order. Holds each channel for a programmable dwell time, then samples the mux output y. After the last enabled channel it publishes the sampled 4-bit frame with a one-cycle valid pulse, giving time-division readout of inputs a, b, c, d over one wire.

Parameters:
DWELL, 4, clock cycles each channel is selected before y is sampled; legal range 2..255.
CNT_W, 8, dwell counter width; must satisfy DWELL-1 < 2**CNT_W.

Ports:
clk  input  1  system clock; all state changes on rising edge.
rst  input  1  asynchronous, active-high reset.
en  input  1  scan enable; level-sensitive.
mask  input  4  channel enable; bit i = channel i (0=a, 1=b, 2=c, 3=d); latched at frame start.
y  input  1  mux output fed back for sampling.
sel1  output  1  mux select MSB, registered.
sel2  output  1  mux select LSB, registered.
frame  output  4  last completed frame; bit i = sampled y for channel i, 0 for masked channels.
frame_valid  output  1  one-cycle pulse when frame updates.
busy  output  1  high in SCAN and DONE states.

Behaviour:
- Channel index ch = {sel1, sel2}: 00→a, 01→b, 10→c, 11→d.
- Reset (async, any time including mid-scan): state=IDLE, sel1=sel2=0, frame=0, frame_valid=0, busy=0, dwell counter=0, latched mask=0, shadow=0. No frame is produced for an interrupted scan.
- States: IDLE, SCAN, DONE.
- IDLE:
  - sel=00; busy=0.
  - On an edge with en=1 and mask≠0: latch mask; set ch to the lowest set bit; load cnt=DWELL-1; go to SCAN.
  - If en=1 and mask=0: stay in IDLE.
- SCAN, each edge:
  - If cnt≠0: cnt←cnt-1; ch is held.
  - If cnt=0: shadow[ch]←y.
  - If a higher set bit exists in the latched mask: ch←next set bit; cnt←DWELL-1.
  - Otherwise: frame←shadow-with-this-sample AND latched mask; go to DONE.
  - Each enabled channel is therefore selected for exactly DWELL cycles. y is sampled at the edge that ends its dwell, giving DWELL-1 settle cycles.
- DONE (exactly one cycle):
  - frame_valid=1; sel holds the last channel.
  - Next edge: if en=1 and the current mask≠0, relatch mask and restart at its lowest set bit (same as the IDLE exit). Otherwise go to IDLE, sel=00.
- en deasserted during SCAN: the current frame completes normally. en is only examined in IDLE and DONE.
- mask changes during SCAN are ignored until the next frame start.
- Latency: with k enabled channels, the edge where en is seen in IDLE is edge 0. frame/frame_valid update at edge k·DWELL. Back-to-back frame period is k·DWELL+1 cycles.
- frame holds its value between pulses. shadow bits of skipped channels never leak into frame.
- sel1/sel2 come straight from flops: no combinational path from en/mask/y to outputs.

Decomposition:
- Shared header, included by this block and its bench:
  - state encodings IDLE=2'd0, SCAN=2'd1, DONE=2'd2;
  - channel index width 2;
  - channel constants CH_A..CH_D = 0..3.
- The next-set-bit search (latched mask, current ch → next ch, found flag) is a pure function in the same file.
- One sub-module: mux4_dwell_counter. Inputs: load, load value, decrement enable. Output: zero flag. Instantiated once.
- The bench instantiates the existing 4-to-1 multiplexer between mux4_scan_ctrl and the stimulus, closing the y loop.

Test Plan:
1. Reset: assert rst mid-scan between clock edges. Required: sel=00, busy=0, frame=0, frame_valid=0 immediately. No frame_valid after rst drops while en=0.
2. Full scan, DWELL=4, mask=1111, a=1 b=0 c=1 d=0, en pulsed for one cycle.
   - sel must be 00 for 4 cycles, then 01, 10, 11 (4 cycles each).
   - frame_valid must be high for exactly 1 cycle at edge 16, with frame=0101.
   - Then IDLE with sel=00.
3. Sparse mask=1010, b=1 d=1 a=1 c=1. Required: only sel=01 then 11 are visited; frame=1010 (a, c masked); frame_valid at edge 8.
4. Masked/empty cases:
   - mask=0000 with en=1 held for 50 cycles → busy=0 and no frame_valid.
   - Change mask 1111→0001 mid-scan → current frame still visits all 4 channels; the next frame visits only 00.
5. Continuous en=1, mask=1111, DWELL=4:
   - frame_valid pulses must be spaced 17 cycles apart.
   - Toggling d between frames must flip frame[3] in the following frame only.
6. DWELL=2 build, mask=0001, a toggling every cycle. Required: sampled value equals a at the dwell-end edge; period 3 cycles.
